// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small FIFO feeding an 8N1 serializer, frames sent back-to-back.
// Define UART_TX_PARITY_EN to build an 8E1 frame with an even-parity cell after bit 7.
module uart_tx_fifo #(
    parameter int DELAY_FRAMES    = 234,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic                       uart_tx,
    output logic                       busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [12:0] BAUD_LAST = 13'(DELAY_FRAMES - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       push;
    logic                       pop;
    logic                       empty;

    state_t      state;
    state_t      state_next;
    logic [12:0] baud_cnt;
    logic [12:0] baud_next;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        tx_next;
    logic        baud_done;

    assign empty      = (count == '0);
    assign data_ready = !rst && (count != FULL_COUNT);
    assign push       = data_valid && data_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);
    assign baud_done  = (baud_cnt == BAUD_LAST);

    // Storage is left unreset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            uart_tx   <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            uart_tx   <= tx_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    // The byte is copied out of the FIFO at the pop, so later pushes cannot disturb the frame.
    always_comb begin
        state_next = state;
        tx_next    = uart_tx;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    tx_next    = 1'b0;
                    bit_next   = '0;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 13'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = ^shift_reg;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                        tx_next  = shift_reg[bit_cnt + 3'd1];
                    end
                end else begin
                    baud_next = baud_cnt + 13'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 13'd1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        tx_next    = 1'b0;
                        bit_next   = '0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 13'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DELAY_FRAMES=4, depth 4; builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NCELLS = 11;
`else
    localparam int NCELLS = 10;
`endif
    localparam int FRAME = NCELLS * D;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] cells;
    } frame_vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks;
    int fails;
    int cycle_cnt;

    frame_vec_t vecs [4];

    uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH_LOG2(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle_cnt, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int target);
        while (cycle_cnt < target) waitCycle();
    endtask

    // Drives one byte for a single edge; data_valid is left high for back-to-back pushes.
    task automatic applyStimulus(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        waitCycle();
    endtask

    // Serial receiver sampling mid-cell; t0 is the cycle of the first start-cell sample.
    task automatic recvByte(output logic [7:0] b, output logic ok, output int t0);
        logic found;
        logic start_ok;
        found = 1'b0;
        ok    = 1'b0;
        b     = '0;
        t0    = 0;
        for (int w = 0; w < 400 && !found; w++) begin
            waitCycle();
            if (uart_tx === 1'b0) found = 1'b1;
        end
        if (found) begin
            t0 = cycle_cnt;
            repeat (2) waitCycle();
            start_ok = (uart_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (D) waitCycle();
                b[i] = uart_tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (D) waitCycle();
`endif
            repeat (D) waitCycle();
            ok = start_ok && (uart_tx === 1'b1);
        end
    endtask

    logic [7:0] rb0, rb1;
    logic       rok0, rok1;
    int         rt0, rt1;
    int         k, accepted;
    logic       rdy;
    logic       stray;

    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{data: 8'h55, cells: 11'h4AA};
        vecs[1] = '{data: 8'h07, cells: 11'h60E};
        vecs[2] = '{data: 8'h03, cells: 11'h406};
        vecs[3] = '{data: 8'hA5, cells: 11'h54A};
`else
        vecs[0] = '{data: 8'h55, cells: 11'h2AA};
        vecs[1] = '{data: 8'hFF, cells: 11'h3FE};
        vecs[2] = '{data: 8'hA5, cells: 11'h34A};
        vecs[3] = '{data: 8'h00, cells: 11'h200};
`endif

        repeat (2) waitCycle();
        checkOutput("reset_tx", uart_tx, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_ready", data_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", data_ready, 1);
        waitCycle();

        // Single frames, checked every cycle from the edge after the push.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].data);
            data_valid = 1'b0;
            for (int i = 0; i < NCELLS; i++) begin
                for (int c = 0; c < D; c++) begin
                    waitCycle();
                    checkOutput($sformatf("frame%0d_cell%0d", v, i), uart_tx, vecs[v].cells[i]);
                    if (c == 0) checkOutput($sformatf("frame%0d_busy", v), busy, 1);
                end
            end
            waitCycle();
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_tx", uart_tx, 1);
        end

        // Two pushes on consecutive edges leave no gap between frames.
        fork
            begin
                applyStimulus(8'h31);
                applyStimulus(8'h32);
                data_valid = 1'b0;
            end
            begin
                recvByte(rb0, rok0, rt0);
                recvByte(rb1, rok1, rt1);
            end
        join
        checkOutput("b2b_byte0", rb0, 8'h31);
        checkOutput("b2b_ok0", rok0, 1);
        checkOutput("b2b_byte1", rb1, 8'h32);
        checkOutput("b2b_ok1", rok1, 1);
        checkOutput("b2b_gap", rt1 - rt0, FRAME);
        waitUntil(rt0 + 2 * FRAME - 1);
        checkOutput("b2b_busy_end", busy, 1);
        waitCycle();
        checkOutput("b2b_busy_fall", busy, 0);

        // Holding data_valid fills the FIFO; ready returns after the next pop.
        fork
            begin
                accepted   = 0;
                data_valid = 1'b1;
                for (int s = 0; s < 8; s++) begin
                    data_in = 8'h10 + 8'(accepted);
                    checkOutput($sformatf("fill_ready%0d", s), data_ready, (s < 5) ? 1 : 0);
                    rdy = data_ready;
                    waitCycle();
                    if (s == 0) k = cycle_cnt;
                    if (rdy) accepted++;
                end
                data_valid = 1'b0;
                checkOutput("fill_accepted", accepted, 5);
                checkOutput("fill_count", fifo_count, 4);
                checkOutput("fill_ready_low", data_ready, 0);
                waitUntil(k + 40);
                checkOutput("ready_before_pop", data_ready, 0);
                waitCycle();
                checkOutput("ready_after_pop", data_ready, 1);
                checkOutput("count_after_pop", fifo_count, 3);
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    recvByte(rb0, rok0, rt0);
                    checkOutput($sformatf("fill_byte%0d", j), rb0, 8'h10 + j);
                    checkOutput($sformatf("fill_ok%0d", j), rok0, 1);
                end
            end
        join
        repeat (4) waitCycle();
        checkOutput("fill_idle_busy", busy, 0);

        // Reset during bit 3 of 0xA5 with two bytes queued.
        applyStimulus(8'hA5);
        k = cycle_cnt;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        data_valid = 1'b0;
        checkOutput("rst_queue_count", fifo_count, 2);
        waitUntil(k + 17);
        checkOutput("rst_bit3_value", uart_tx, 0);
        waitCycle();
        rst = 1'b1;
        #1;
        checkOutput("rst_ready_low", data_ready, 0);
        waitCycle();
        rst = 1'b0;
        checkOutput("rst_tx", uart_tx, 1);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_busy", busy, 0);
        stray = 1'b0;
        repeat (60) begin
            waitCycle();
            if (uart_tx !== 1'b1 || busy !== 1'b0) stray = 1'b1;
        end
        checkOutput("rst_no_resume", stray, 0);

        // Push coinciding with a pop at fifo_count=2; order kept across pointer wrap.
        fork
            begin
                applyStimulus(8'h61);
                k = cycle_cnt;
                applyStimulus(8'h62);
                applyStimulus(8'h63);
                data_valid = 1'b0;
                checkOutput("sim_count_pre", fifo_count, 2);
                waitUntil(k + 40);
                checkOutput("sim_count_before", fifo_count, 2);
                applyStimulus(8'h64);
                data_valid = 1'b0;
                checkOutput("sim_count_after", fifo_count, 2);
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    recvByte(rb0, rok0, rt0);
                    checkOutput($sformatf("sim_byte%0d", j), rb0, 8'h61 + j);
                    checkOutput($sformatf("sim_ok%0d", j), rok0, 1);
                end
            end
        join
        repeat (4) waitCycle();
        checkOutput("final_busy", busy, 0);
        checkOutput("final_count", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
